// File: rtl/issue_scheduler.sv
// Slot allocation, operand wakeup and oldest-index select for the instruction queue.
// Hands out free slot addresses, tracks operand readiness and issues one entry per cycle.
module issue_scheduler #(
    parameter int ENTRIES         = 64,
    parameter int ADDR_WIDTH      = $clog2(ENTRIES),
    parameter int PHYS_COUNT      = 128,
    parameter int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT)
) (
    input  logic                         clk_i,
    input  logic                         sync_rst_n_i,
    input  logic                         clk_en_i,
    input  logic                         flush_i,
    input  logic                         alloc_valid_i,
    output logic                         alloc_ready_o,
    input  logic [2*PHYS_ADDR_WIDTH-1:0] alloc_src_tag_i,
    input  logic [1:0]                   alloc_src_valid_i,
    input  logic [1:0]                   alloc_src_ready_i,
    output logic                         queue_wr_en_o,
    output logic [ADDR_WIDTH-1:0]        queue_wr_addr_o,
    input  logic                         wb_valid_i,
    input  logic [PHYS_ADDR_WIDTH-1:0]   wb_tag_i,
    output logic                         queue_rd_en_o,
    output logic [ADDR_WIDTH-1:0]        queue_rd_addr_o,
    output logic                         issue_valid_o,
    output logic [ADDR_WIDTH-1:0]        issue_idx_o,
    input  logic                         issue_ready_i,
    output logic [ADDR_WIDTH:0]          occupancy_o
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(ENTRIES);

    logic [ENTRIES-1:0]         valid_q, valid_d;
    logic [ENTRIES-1:0]         issued_q, issued_d;
    logic [ENTRIES-1:0]         rdy0_q, rdy0_d;
    logic [ENTRIES-1:0]         rdy1_q, rdy1_d;
    logic [PHYS_ADDR_WIDTH-1:0] tag0_q [ENTRIES];
    logic [PHYS_ADDR_WIDTH-1:0] tag0_d [ENTRIES];
    logic [PHYS_ADDR_WIDTH-1:0] tag1_q [ENTRIES];
    logic [PHYS_ADDR_WIDTH-1:0] tag1_d [ENTRIES];
    logic                       issue_valid_q, issue_valid_d;
    logic [ADDR_WIDTH-1:0]      issue_idx_q, issue_idx_d;
    logic [ADDR_WIDTH:0]        occ_q, occ_d;

    logic [ENTRIES-1:0]         cand;
    logic [ADDR_WIDTH-1:0]      free_idx;
    logic [ADDR_WIDTH-1:0]      sel_idx;
    logic                       alloc_ready;
    logic                       alloc_fire;
    logic                       handshake;
    logic                       sel_fire;
    logic [PHYS_ADDR_WIDTH-1:0] new_tag0, new_tag1;
    logic                       new_rdy0, new_rdy1;

    assign cand = valid_q & ~issued_q & rdy0_q & rdy1_q;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = ADDR_WIDTH'(i);
            end
            if (cand[i]) begin
                sel_idx = ADDR_WIDTH'(i);
            end
        end
    end

    assign alloc_ready = clk_en_i && !flush_i && (occ_q != FULL_CNT);
    assign alloc_fire  = alloc_valid_i && alloc_ready;
    assign handshake   = clk_en_i && !flush_i && issue_valid_q && issue_ready_i;
    assign sel_fire    = clk_en_i && !flush_i && (|cand) && (!issue_valid_q || issue_ready_i);

    // A writeback landing in the allocation cycle is folded into the initial ready bits.
    assign new_tag0 = alloc_src_tag_i[PHYS_ADDR_WIDTH-1:0];
    assign new_tag1 = alloc_src_tag_i[2*PHYS_ADDR_WIDTH-1:PHYS_ADDR_WIDTH];
    assign new_rdy0 = !alloc_src_valid_i[0] || alloc_src_ready_i[0] || (wb_valid_i && (wb_tag_i == new_tag0));
    assign new_rdy1 = !alloc_src_valid_i[1] || alloc_src_ready_i[1] || (wb_valid_i && (wb_tag_i == new_tag1));

    always_comb begin
        valid_d       = valid_q;
        issued_d      = issued_q;
        rdy0_d        = rdy0_q;
        rdy1_d        = rdy1_q;
        tag0_d        = tag0_q;
        tag1_d        = tag1_q;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;
        occ_d         = occ_q;
        if (clk_en_i && flush_i) begin
            valid_d       = '0;
            issued_d      = '0;
            rdy0_d        = '0;
            rdy1_d        = '0;
            issue_valid_d = 1'b0;
            occ_d         = '0;
        end else if (clk_en_i) begin
            if (wb_valid_i) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    rdy0_d[i] = rdy0_q[i] | (valid_q[i] && (tag0_q[i] == wb_tag_i));
                    rdy1_d[i] = rdy1_q[i] | (valid_q[i] && (tag1_q[i] == wb_tag_i));
                end
            end
            if (handshake) begin
                valid_d[issue_idx_q]  = 1'b0;
                issued_d[issue_idx_q] = 1'b0;
                issue_valid_d         = 1'b0;
            end
            // free_idx comes from the pre-release state, so a slot freed this cycle is not reused.
            if (alloc_fire) begin
                valid_d[free_idx]  = 1'b1;
                issued_d[free_idx] = 1'b0;
                tag0_d[free_idx]   = new_tag0;
                tag1_d[free_idx]   = new_tag1;
                rdy0_d[free_idx]   = new_rdy0;
                rdy1_d[free_idx]   = new_rdy1;
            end
            if (sel_fire) begin
                issued_d[sel_idx] = 1'b1;
                issue_valid_d     = 1'b1;
                issue_idx_d       = sel_idx;
            end
            occ_d = occ_q + {{ADDR_WIDTH{1'b0}}, alloc_fire} - {{ADDR_WIDTH{1'b0}}, handshake};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_n_i) begin
            valid_q       <= '0;
            issued_q      <= '0;
            rdy0_q        <= '0;
            rdy1_q        <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            occ_q         <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag0_q[i] <= '0;
                tag1_q[i] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            issued_q      <= issued_d;
            rdy0_q        <= rdy0_d;
            rdy1_q        <= rdy1_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            occ_q         <= occ_d;
            tag0_q        <= tag0_d;
            tag1_q        <= tag1_d;
        end
    end

    // Handshake: issue_valid_o/issue_idx_o hold steady until issue_ready_i is seen high
    // on a rising edge with clk_en_i high and flush_i low; the slot is released on that edge.
    assign alloc_ready_o   = alloc_ready;
    assign queue_wr_en_o   = alloc_fire;
    assign queue_wr_addr_o = free_idx;
    assign queue_rd_en_o   = sel_fire;
    assign queue_rd_addr_o = sel_idx;
    assign issue_valid_o   = issue_valid_q;
    assign issue_idx_o     = issue_idx_q;
    assign occupancy_o     = occ_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a slot-level behavioural model.
module tb_issue_scheduler;

    localparam int ENTRIES = 64;
    localparam int AW      = 6;
    localparam int PAW     = 7;

    logic           clk = 1'b0;
    logic           sync_rst_n;
    logic           clk_en;
    logic           flush;
    logic           alloc_valid;
    logic           alloc_ready;
    logic [2*PAW-1:0] alloc_src_tag;
    logic [1:0]     alloc_src_valid;
    logic [1:0]     alloc_src_ready;
    logic           queue_wr_en;
    logic [AW-1:0]  queue_wr_addr;
    logic           wb_valid;
    logic [PAW-1:0] wb_tag;
    logic           queue_rd_en;
    logic [AW-1:0]  queue_rd_addr;
    logic           issue_valid;
    logic [AW-1:0]  issue_idx;
    logic           issue_ready;
    logic [AW:0]    occupancy;

    always #5 clk = ~clk;

    issue_scheduler #(.ENTRIES(ENTRIES), .PHYS_COUNT(128)) dut (
        .clk_i            (clk),
        .sync_rst_n_i     (sync_rst_n),
        .clk_en_i         (clk_en),
        .flush_i          (flush),
        .alloc_valid_i    (alloc_valid),
        .alloc_ready_o    (alloc_ready),
        .alloc_src_tag_i  (alloc_src_tag),
        .alloc_src_valid_i(alloc_src_valid),
        .alloc_src_ready_i(alloc_src_ready),
        .queue_wr_en_o    (queue_wr_en),
        .queue_wr_addr_o  (queue_wr_addr),
        .wb_valid_i       (wb_valid),
        .wb_tag_i         (wb_tag),
        .queue_rd_en_o    (queue_rd_en),
        .queue_rd_addr_o  (queue_rd_addr),
        .issue_valid_o    (issue_valid),
        .issue_idx_o      (issue_idx),
        .issue_ready_i    (issue_ready),
        .occupancy_o      (occupancy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit             m_valid [ENTRIES];
    bit             m_issued[ENTRIES];
    bit             m_rdy   [ENTRIES][2];
    logic [PAW-1:0] m_tag   [ENTRIES][2];
    bit             m_iv;
    int             m_idx;
    bit             model_ok = 1'b0;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < ENTRIES; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < ENTRIES; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic int m_first_cand();
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && !m_issued[i] && m_rdy[i][0] && m_rdy[i][1]) return i;
        return -1;
    endfunction

    int cnt, ff, fc;
    bit exp_ar, exp_wr, exp_rd, hs, afire, sfire;
    logic [PAW-1:0] atag;

    always @(negedge clk) begin
        if (!sync_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0; m_issued[i] = 0; m_rdy[i][0] = 0; m_rdy[i][1] = 0;
            end
            m_iv = 0; m_idx = 0; model_ok = 1'b1;
        end else if (model_ok) begin
            cnt = m_count();
            ff  = m_first_free();
            fc  = m_first_cand();
            exp_ar = clk_en && !flush && (cnt < ENTRIES);
            exp_wr = alloc_valid && exp_ar;
            exp_rd = clk_en && !flush && (fc >= 0) && (!m_iv || issue_ready);
            chk("alloc_ready", 32'(alloc_ready), 32'(exp_ar));
            chk("queue_wr_en", 32'(queue_wr_en), 32'(exp_wr));
            if (cnt < ENTRIES) chk("queue_wr_addr", 32'(queue_wr_addr), 32'(ff));
            chk("queue_rd_en", 32'(queue_rd_en), 32'(exp_rd));
            if (exp_rd) chk("queue_rd_addr", 32'(queue_rd_addr), 32'(fc));
            chk("issue_valid", 32'(issue_valid), 32'(m_iv));
            if (m_iv) chk("issue_idx", 32'(issue_idx), 32'(m_idx));
            chk("occupancy", 32'(occupancy), 32'(cnt));
            // Advance the model to the state after the coming rising edge.
            if (clk_en && flush) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    m_valid[i] = 0; m_issued[i] = 0; m_rdy[i][0] = 0; m_rdy[i][1] = 0;
                end
                m_iv = 0;
            end else if (clk_en) begin
                hs    = m_iv && issue_ready;
                afire = exp_wr;
                sfire = exp_rd;
                if (wb_valid)
                    for (int i = 0; i < ENTRIES; i++)
                        for (int k = 0; k < 2; k++)
                            if (m_valid[i] && m_tag[i][k] == wb_tag) m_rdy[i][k] = 1;
                if (hs) begin
                    m_valid[m_idx] = 0; m_issued[m_idx] = 0; m_iv = 0;
                end
                if (afire) begin
                    m_valid[ff] = 1; m_issued[ff] = 0;
                    for (int k = 0; k < 2; k++) begin
                        atag = alloc_src_tag[k*PAW +: PAW];
                        m_tag[ff][k] = atag;
                        m_rdy[ff][k] = !alloc_src_valid[k] || alloc_src_ready[k] || (wb_valid && wb_tag == atag);
                    end
                end
                if (sfire) begin
                    m_issued[fc] = 1; m_iv = 1; m_idx = fc;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic idle();
        clk_en = 1; flush = 0; alloc_valid = 0; alloc_src_tag = '0;
        alloc_src_valid = 2'b00; alloc_src_ready = 2'b00;
        wb_valid = 0; wb_tag = '0; issue_ready = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        sync_rst_n = 0; idle(); cyc(); cyc(); sync_rst_n = 1;
    endtask

    task automatic set_alloc(input logic [PAW-1:0] t0, input logic [1:0] sv, input logic [1:0] sr);
        alloc_valid = 1; alloc_src_valid = sv; alloc_src_ready = sr;
        alloc_src_tag = {PAW'($urandom_range(64, 127)), t0};
    endtask

    initial begin
        sync_rst_n = 0; idle();

        // Reset then fill
        do_reset();
        at_neg();
        chk("rst_alloc_ready", 32'(alloc_ready), 1);
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_issue_idx", 32'(issue_idx), 0);
        chk("rst_wr_addr", 32'(queue_wr_addr), 0);
        chk("rst_rd_addr", 32'(queue_rd_addr), 0);
        chk("rst_rd_en", 32'(queue_rd_en), 0);
        cyc();
        for (int i = 0; i < ENTRIES; i++) begin
            set_alloc(PAW'($urandom_range(0, 127)), 2'($urandom_range(0, 3)), 2'b11);
            at_neg();
            chk("fill_wr_addr", 32'(queue_wr_addr), i);
            cyc();
        end
        alloc_valid = 0;
        at_neg();
        chk("full_alloc_ready", 32'(alloc_ready), 0);
        chk("full_occupancy", 32'(occupancy), 64);
        chk("full_issue_valid", 32'(issue_valid), 1);
        chk("full_issue_idx", 32'(issue_idx), 0);
        chk("stall_rd_en", 32'(queue_rd_en), 0);
        cyc();

        // Full with simultaneous handshake on slot 3
        do_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            if (i < 3) set_alloc(7'd7, 2'b01, 2'b00);
            else       set_alloc(7'd7, 2'b00, 2'b00);
            cyc();
        end
        alloc_valid = 0; cyc();
        set_alloc(7'd1, 2'b00, 2'b00); issue_ready = 1;
        at_neg();
        chk("hs_full_alloc_ready", 32'(alloc_ready), 0);
        chk("hs_full_issue_idx", 32'(issue_idx), 3);
        chk("hs_full_wr_en", 32'(queue_wr_en), 0);
        cyc();
        issue_ready = 0;
        at_neg();
        chk("after_hs_alloc_ready", 32'(alloc_ready), 1);
        chk("after_hs_wr_addr", 32'(queue_wr_addr), 3);
        chk("after_hs_occupancy", 32'(occupancy), 63);
        chk("after_hs_issue_idx", 32'(issue_idx), 4);
        cyc();
        alloc_valid = 0;

        // Flush mid-operation
        flush = 1;
        at_neg();
        chk("flush_alloc_ready", 32'(alloc_ready), 0);
        cyc();
        flush = 0;
        for (int i = 0; i < 10; i++) begin
            set_alloc(7'd0, 2'b00, 2'b00);
            cyc();
        end
        alloc_valid = 0;
        at_neg();
        chk("ten_occupancy", 32'(occupancy), 10);
        chk("ten_issue_valid", 32'(issue_valid), 1);
        cyc();
        flush = 1; cyc(); flush = 0;
        set_alloc(7'd0, 2'b00, 2'b00);
        at_neg();
        chk("post_flush_occupancy", 32'(occupancy), 0);
        chk("post_flush_issue_valid", 32'(issue_valid), 0);
        chk("post_flush_wr_addr", 32'(queue_wr_addr), 0);
        cyc();
        alloc_valid = 0; flush = 1; cyc(); flush = 0;

        // Wakeup ordering
        set_alloc(7'd5, 2'b01, 2'b00); cyc();
        set_alloc(7'd20, 2'b00, 2'b00); cyc();
        alloc_valid = 0; issue_ready = 1;
        at_neg();
        chk("wk_first_rd_addr", 32'(queue_rd_addr), 1);
        chk("wk_first_rd_en", 32'(queue_rd_en), 1);
        cyc();
        at_neg();
        chk("wk_first_issue_idx", 32'(issue_idx), 1);
        cyc();
        wb_valid = 1; wb_tag = 7'd5;
        at_neg();
        chk("wk_before_rd_en", 32'(queue_rd_en), 0);
        cyc();
        wb_valid = 0;
        at_neg();
        chk("wk_n1_rd_en", 32'(queue_rd_en), 1);
        chk("wk_n1_rd_addr", 32'(queue_rd_addr), 0);
        cyc();
        at_neg();
        chk("wk_n2_issue_valid", 32'(issue_valid), 1);
        chk("wk_n2_issue_idx", 32'(issue_idx), 0);
        cyc();
        issue_ready = 0;

        // Same-cycle bypass
        set_alloc(7'd9, 2'b01, 2'b00); wb_valid = 1; wb_tag = 7'd9;
        at_neg();
        chk("byp_wr_en", 32'(queue_wr_en), 1);
        cyc();
        alloc_valid = 0; wb_valid = 0;
        at_neg();
        chk("byp_n1_issue_valid", 32'(issue_valid), 0);
        chk("byp_n1_rd_en", 32'(queue_rd_en), 1);
        cyc();
        issue_ready = 1;
        at_neg();
        chk("byp_n2_issue_valid", 32'(issue_valid), 1);
        cyc();
        issue_ready = 0;

        // clk_en gating
        set_alloc(7'd0, 2'b00, 2'b00); cyc();
        set_alloc(7'd12, 2'b01, 2'b00); cyc();
        alloc_valid = 0;
        at_neg();
        chk("gate_pre_issue_idx", 32'(issue_idx), 0);
        chk("gate_pre_occupancy", 32'(occupancy), 2);
        cyc();
        for (int i = 0; i < 5; i++) begin
            clk_en = 0; set_alloc(7'd0, 2'b00, 2'b00);
            wb_valid = 1; wb_tag = 7'd12; issue_ready = 1;
            at_neg();
            chk("gate_alloc_ready", 32'(alloc_ready), 0);
            chk("gate_wr_en", 32'(queue_wr_en), 0);
            chk("gate_rd_en", 32'(queue_rd_en), 0);
            chk("gate_occupancy", 32'(occupancy), 2);
            cyc();
        end
        clk_en = 1; alloc_valid = 0; wb_valid = 0; issue_ready = 1;
        at_neg();
        chk("gate_lost_wake_rd_en", 32'(queue_rd_en), 0);
        cyc();
        issue_ready = 0;
        at_neg();
        chk("gate_post_occupancy", 32'(occupancy), 1);
        chk("gate_post_issue_valid", 32'(issue_valid), 0);
        chk("gate_post_rd_en", 32'(queue_rd_en), 0);
        cyc();

        // Random traffic in phases with different drain pressure
        for (int p = 0; p < 8; p++) begin
            int ready_pct = (p % 4 == 0) ? 10 : ((p % 4 == 1) ? 90 : 50);
            for (int c = 0; c < 500; c++) begin
                clk_en          = ($urandom_range(0, 9) != 0);
                flush           = ($urandom_range(0, 199) == 0);
                alloc_valid     = ($urandom_range(0, 99) < 70);
                alloc_src_tag   = {PAW'($urandom_range(0, 15)), PAW'($urandom_range(0, 15))};
                alloc_src_valid = 2'($urandom_range(0, 3));
                alloc_src_ready = 2'($urandom_range(0, 3));
                wb_valid        = ($urandom_range(0, 99) < 40);
                wb_tag          = PAW'($urandom_range(0, 15));
                issue_ready     = ($urandom_range(0, 99) < ready_pct);
                cyc();
            end
        end
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Allocation and issue controller for the `instruction_queue` storage array, sitting between rename/dispatch and the execution units. It tracks which queue slots are occupied and which source operands are ready, and hands each incoming instruction a free slot address. It selects one ready entry per cycle for issue, drives the queue's write and read ports, and presents the issued slot index to the execute stage through a valid/ready handshake.

## Interface
- `ENTRIES`, 64, number of queue slots; power of two, at least 4.
- `ADDR_WIDTH`, `$clog2(ENTRIES)`, slot index width.
- `PHYS_COUNT`, 128, number of physical registers.
- `PHYS_ADDR_WIDTH`, `$clog2(PHYS_COUNT)`, physical register tag width.
- `clk` in 1: single clock; all state updates on rising edge.
- `sync_rst_n` in 1: synchronous, active-low reset.
- `clk_en` in 1: when low, all state holds and all strobes (`alloc_ready`, `queue_wr_en`, `queue_rd_en`) are forced low.
- `flush` in 1: discards all entries and any pending issue.
- `alloc_valid` in 1: dispatch presents an instruction.
- `alloc_ready` out 1: a free slot exists; allocation fires on `alloc_valid && alloc_ready`.
- `alloc_src_tag` in 2×PHYS_ADDR_WIDTH: source physical tags.
- `alloc_src_valid` in 2×1: the source is used; an unused source counts as ready.
- `alloc_src_ready` in 2×1: the source is already ready according to the rename scoreboard.
- `queue_wr_en` out 1: equals allocation fire.
- `queue_wr_addr` out ADDR_WIDTH: lowest-index free slot.
- `wb_valid` in 1, `wb_tag` in PHYS_ADDR_WIDTH: writeback wakeup broadcast.
- `queue_rd_en` out 1, `queue_rd_addr` out ADDR_WIDTH: select strobe and slot index.
- `issue_valid` out 1, `issue_idx` out ADDR_WIDTH, `issue_ready` in 1: issue handshake.
- `occupancy` out ADDR_WIDTH+1: number of valid entries, including an entry held in the issue register.

## Operation
- Per-slot state:
  - `valid`;
  - `src_tag[2]`;
  - `src_rdy[2]`;
  - `issued`, meaning the slot is held in the issue register and not yet released.
- **Allocate.**
  - Free slot = `!valid`. `queue_wr_addr` = lowest-index free slot, from a priority encoder.
  - `alloc_ready` = `clk_en && !flush && (occupancy != ENTRIES)`.
  - On fire, the slot loads `valid=1`, `issued=0`, the source tags, and `src_rdy[k] = !alloc_src_valid[k] || alloc_src_ready[k] || (wb_valid && wb_tag == alloc_src_tag[k])`. The last term is the same-cycle wakeup bypass.
- **Wakeup.** When `wb_valid` is high, every valid slot with `src_tag[k] == wb_tag` sets `src_rdy[k]`. An already-set bit is unaffected.
- **Select.**
  - Candidate = `valid && !issued && src_rdy[0] && src_rdy[1]`.
  - The lowest-index candidate wins (fixed priority).
  - Select fires when a candidate exists, `clk_en=1`, `flush=0`, and the issue register is empty or being drained this cycle (`issue_valid && issue_ready`).
  - On fire: `queue_rd_en=1`, `queue_rd_addr` = winner, `issued[winner]` is set, and the issue register loads the winner.
- **Issue handshake.**
  - `issue_valid`/`issue_idx` are registered.
  - Once `issue_valid` is asserted, `issue_idx` stays stable until the `issue_valid && issue_ready` handshake completes.
  - On handshake the slot becomes free: `valid=0`, `issued=0`.
- **Occupancy** = `occupancy + alloc_fire - issue_handshake`, registered.
- **Flush.** When `flush` is high (with `clk_en` high), all `valid`, `issued`, `src_rdy` and `issue_valid` clear and `occupancy`=0. Allocation, select and handshake are suppressed that cycle.
- **Priority:** reset > flush > normal operation.
- **`clk_en` low:** no state changes, including wakeups, which are lost (the broadcaster must hold `wb_valid` with `clk_en`).

## Timing
- **Reset:** `alloc_ready` reads 1 after reset when `clk_en=1` (combinational). All other outputs are 0: `queue_wr_en`, `queue_rd_en`, `issue_valid`, `issue_idx`, `occupancy`, `queue_wr_addr`, `queue_rd_addr`.
- **Minimum latency:**
  - Allocation with both sources ready at cycle N → select in N+1 (`queue_rd_en` high) → `issue_valid` in N+2.
  - Wakeup in cycle N makes the entry selectable in N+1.
  - A bypassed wakeup at allocation behaves as ready-at-allocation.
- **Throughput:**
  - One allocation and one select per cycle.
  - With `issue_ready` held high, back-to-back issues occur every cycle.
- **Slot reuse:** a slot released by handshake in cycle N is allocatable from N+1; it is not reused in the same cycle.
- **Full:** with `occupancy`=ENTRIES, `alloc_ready`=0 even if a handshake completes that cycle.
- **Stall:** `issue_ready` low with `issue_valid` high means select does not fire and `queue_rd_en`=0.
- **Queue read data:** the queue presents read data for `queue_rd_addr` aligned with `issue_valid` (one-cycle registered read).

## Test plan
- **Reset then fill.** Reset, then 64 allocations with ready sources and `issue_ready=0`.
  - `queue_wr_addr` = 0..63 in order.
  - `alloc_ready` drops after the 64th; `occupancy`=64.
  - `issue_idx`=0 is held with `issue_valid` high.
- **Wakeup ordering.** Allocate slot 0 with src tag 5 not ready, and slot 1 ready.
  - Slot 1 issues first.
  - `wb_valid`/`wb_tag`=5 in cycle N gives `queue_rd_addr`=0 in N+1 and `issue_idx`=0 in N+2.
- **Same-cycle bypass.** Allocate with tag 9 not ready while `wb_tag`=9 → `issue_valid` exactly 2 cycles after allocation.
- **Full with simultaneous handshake.** At `occupancy`=64, complete a handshake on slot 3.
  - `alloc_ready` stays 0 that cycle.
  - Next cycle `alloc_ready`=1 and `queue_wr_addr`=3.
- **Flush mid-operation.** With 10 entries and `issue_valid` high, pulse `flush`.
  - Next cycle `occupancy`=0 and `issue_valid`=0.
  - The next allocation gets slot 0.
- **clk_en gating.** Hold `clk_en` low for 5 cycles with `alloc_valid`, `wb_valid` and `issue_ready` high.
  - No state change and all strobes 0.
  - The wakeup is not applied.
